uart_tx_pop: RTL and testbench

Serial UART transmitter that drains the 4-byte transmit FIFO and shifts each byte out on a single TX line. Sits directly downstream of the `fifo` block: it watches the FIFO's empty flag, pops one byte per frame using the FIFO's pop strobe, and drives the UART pin. Frames are 8N1 by default, with optional even parity and a configurable stop-bit count.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_baud_cnt.sv | 38 +++
 rtl/uart_tx_pop.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_pop.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and the future receiver.
//   uart_tx_state_t : transmitter FSM state encoding
//   UART_DATA_BITS  : data bits per frame
//   even_parity()   : XOR reduction of a data byte
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_tx_state_t;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] dat);
        return ^dat;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: divide-by-CLKS_PER_BIT counter marking serial bit boundaries.
// Ports:
//   i_clk     : clock, rising edge
//   i_reset   : synchronous active-high reset
//   i_clr     : synchronous clear, restarts the current bit
//   o_bit_end : high in the last cycle of each bit (counter at CLKS_PER_BIT-1)
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    output logic o_bit_end
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clr || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_end = (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx_pop.sv
// uart_tx_pop: UART transmitter that pops bytes from an upstream FIFO and
// shifts them out LSB first as 8N1 frames (optional even parity, 1 or 2 stops).
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit after data).
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : synchronous active-high reset
//   i_dat   : FIFO head byte, valid while i_empty = 0
//   i_empty : FIFO empty flag
//   o_pop   : single-cycle pop strobe, asserted in the load cycle
//   o_tx    : serial line, idles high
//   o_busy  : high whenever the FSM is not idle
module uart_tx_pop
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_dat,
    input  logic       i_empty,
    output logic       o_pop,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int unsigned BitCntW = $clog2(UART_DATA_BITS);
    localparam logic [BitCntW-1:0] LastDataBit = BitCntW'(UART_DATA_BITS - 1);
    localparam logic [BitCntW-1:0] LastStopBit = BitCntW'(STOP_BITS - 1);

    uart_tx_state_t      state_q, state_d;
    logic [7:0]          shift_q, shift_d;
    logic [BitCntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic                tx_q, tx_d;
    logic                load;
    logic                bit_end;
    logic                baud_clr;
`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    // Held clear while idle so the first bit of a frame is a full CLKS_PER_BIT long.
    assign baud_clr = load || (state_q == StIdle);

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (baud_clr),
        .o_bit_end (bit_end)
    );

    // tx_d is the line level for the next cycle, so o_tx is a plain flop output.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        load      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                load = !i_empty;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    // Counter wraps to zero after the last data bit, ready for STOP.
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastDataBit) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = parity_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (bit_cnt_q == LastStopBit) begin
                        if (i_empty) begin
                            state_d = StIdle;
                        end else begin
                            load = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase

        // No pop may be issued while reset is held.
        if (i_reset) begin
            load = 1'b0;
        end

        if (load) begin
            state_d   = StStart;
            shift_d   = i_dat;
            bit_cnt_d = '0;
            tx_d      = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_d  = even_parity(i_dat);
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_pop  = load;
    assign o_tx   = tx_q;
    assign o_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_pop.sv
// tb_uart_tx_pop: directed self-checking bench for uart_tx_pop.
// Two instances with CLKS_PER_BIT = 4: u_dut1 (STOP_BITS = 1), u_dut2 (STOP_BITS = 2),
// each fed by a small FIFO model. Expectations adapt to UART_TX_PARITY_EN.
module tb_uart_tx_pop;

    localparam int unsigned Cpb = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] dat1, dat2;
    logic       empty1, empty2;
    logic       pop1, pop2, tx1, tx2, busy1, busy2;

    int errors = 0;
    int checks = 0;
    int pops1  = 0;
    int pops2  = 0;
    logic pop_s1 = 1'b0;
    logic pop_s2 = 1'b0;
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    uart_tx_pop #(
        .CLKS_PER_BIT (Cpb),
        .STOP_BITS    (1)
    ) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_dat   (dat1),
        .i_empty (empty1),
        .o_pop   (pop1),
        .o_tx    (tx1),
        .o_busy  (busy1)
    );

    uart_tx_pop #(
        .CLKS_PER_BIT (Cpb),
        .STOP_BITS    (2)
    ) u_dut2 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_dat   (dat2),
        .i_empty (empty2),
        .o_pop   (pop2),
        .o_tx    (tx2),
        .o_busy  (busy2)
    );

    // FIFO models: the pop seen mid-cycle takes effect on the following edge.
    always @(negedge clk) begin
        pop_s1 = pop1;
        pop_s2 = pop2;
        if (pop1) pops1++;
        if (pop2) pops2++;
    end

    always @(posedge clk) begin
        #1;
        if (pop_s1 && q1.size() > 0) void'(q1.pop_front());
        if (pop_s2 && q2.size() > 0) void'(q2.pop_front());
        empty1 = (q1.size() == 0);
        empty2 = (q2.size() == 0);
        dat1   = empty1 ? 8'hC6 : q1[0];
        dat2   = empty2 ? 8'hC6 : q2[0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (P == 1 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic wait_pop(input int sel, input string tag);
        int   n = 0;
        logic seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            seen = (sel == 1) ? pop2 : pop1;
            n++;
        end
        check($sformatf("%s_pop_seen", tag), seen, 1);
    endtask

    // Starts in the pop cycle; ends at the last cycle of the final stop bit.
    task automatic check_frame(input int sel, input string tag, input logic [7:0] b,
                               input int stops);
        int nbits = 9 + P + stops;
        for (int k = 0; k < nbits; k++) begin
            logic [3:0] v;
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                v[j] = (sel == 1) ? tx2 : tx1;
            end
            check($sformatf("%s_bit%0d", tag, k), v, {4{exp_bit(b, k)}});
        end
    endtask

    initial begin
        int   p0;
        logic bad;
        rst    = 1'b1;
        empty1 = 1'b1;
        empty2 = 1'b1;
        dat1   = 8'hC6;
        dat2   = 8'hC6;

        repeat (3) @(negedge clk);
        check("reset_tx", tx1, 1);
        check("reset_pop", pop1, 0);
        check("reset_busy", busy1, 0);
        check("reset_busy2", busy2, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        bad = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || pop1 !== 1'b0 || busy1 !== 1'b0) bad = 1'b1;
        end
        check("idle_50", bad, 0);

        // Single frame
        p0 = pops1;
        q1.push_back(8'h55);
        wait_pop(0, "f55");
        check_frame(0, "f55", 8'h55, 1);
        check("f55_busy_last", busy1, 1);
        @(negedge clk);
        check("f55_busy_end", busy1, 0);
        check("f55_pops", pops1 - p0, 1);

        // Back-to-back frames
        p0 = pops1;
        q1.push_back(8'hA3);
        q1.push_back(8'h0F);
        wait_pop(0, "fa3");
        check_frame(0, "fa3", 8'hA3, 1);
        check("b2b_pop", pop1, 1);
        check_frame(0, "f0f", 8'h0F, 1);
        @(negedge clk);
        check("b2b_busy_end", busy1, 0);
        check("b2b_pops", pops1 - p0, 2);

        // Parity-sensitive bytes
        q1.push_back(8'h07);
        wait_pop(0, "f07");
        check_frame(0, "f07", 8'h07, 1);
        @(negedge clk);
        check("f07_busy_end", busy1, 0);
        q1.push_back(8'h03);
        wait_pop(0, "f03");
        check_frame(0, "f03", 8'h03, 1);
        @(negedge clk);
        check("f03_busy_end", busy1, 0);

        // Two stop bits, back-to-back
        p0 = pops2;
        q2.push_back(8'hFF);
        q2.push_back(8'hFF);
        wait_pop(1, "s2a");
        check_frame(1, "s2a", 8'hFF, 2);
        check("s2_b2b_pop", pop2, 1);
        check_frame(1, "s2b", 8'hFF, 2);
        @(negedge clk);
        check("s2_busy_end", busy2, 0);
        check("s2_pops", pops2 - p0, 2);

        // Reset during data bit 3
        p0 = pops1;
        q1.push_back(8'h52);
        q1.push_back(8'h3C);
        wait_pop(0, "rst");
        repeat (18) @(negedge clk);
        check("rst_pre_tx_bit3", tx1, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_pop_a", pop1, 0);
        @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_busy", busy1, 0);
        check("rst_pop_b", pop1, 0);
        @(negedge clk);
        check("rst_pop_c", pop1, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_pop(0, "rst_new");
        check_frame(0, "rst_new", 8'h3C, 1);
        @(negedge clk);
        check("rst_new_busy_end", busy1, 0);
        check("rst_pops", pops1 - p0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
